// File: rtl/rr_grant_ctrl.sv
// Round-robin ownership arbiter for one shared resource among N requesters.
// Grants one owner at a time, enforces a MAX_HOLD cycle limit and a one-cycle idle gap.
module rr_grant_ctrl #(
  parameter int unsigned N        = 3,
  parameter int unsigned MAX_HOLD = 6,
  localparam int unsigned IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           rel,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;

  logic           any_req;
  logic           vol_release;
  logic           hold_max;
  logic [IDW-1:0] win;
  logic           found;
  int unsigned    idx;

  assign any_req     = |req;
  assign vol_release = rel || !req[gnt_id_q];
  assign hold_max    = (hold_cnt_q == HW'(MAX_HOLD));

  // First requester found scanning upward from ptr, wrapping modulo N.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StGrant;
      StGrant: if (vol_release || hold_max) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs and datapath next values
  always_comb begin
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          gnt_id_d   = win;
          busy_d     = 1'b1;
          hold_cnt_d = HW'(1);
        end
      end
      StGrant: begin
        if (vol_release || hold_max) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
          // A voluntary release in the limit cycle suppresses the pulse.
          timeout_d = !vol_release;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Output logic
  always_comb begin
    gnt     = gnt_q;
    gnt_id  = gnt_id_q;
    busy    = busy_q;
    timeout = timeout_q;
  end

endmodule
